// File: rtl/debug_monitor.sv
// Run-time console/dump monitor for the pipelined core: captures print_flag toggles into a
// FIFO, streams them out, then on halt or watchdog drains, dumps a memory window and ends.
module debug_monitor #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 16,
  parameter logic [ADDR_W-1:0] DUMP_BASE  = '0,
  parameter int unsigned       DUMP_COUNT = 10,
  parameter int unsigned       TIMEOUT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              print_flag,
  input  logic [7:0]        print_data,
  input  logic              halt,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_type,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              overflow,
  output logic              done,
  output logic [31:0]       cycle_count,
  output logic [2:0]        dbg_state
);

  // Stream handshake: a word transfers on a rising edge where out_valid && out_ready; once
  // out_valid is high the payload holds until that edge, and out_valid never looks at out_ready.

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_DUMP_REQ  = 3'd2,
    ST_DUMP_WAIT = 3'd3,
    ST_DUMP_OUT  = 3'd4,
    ST_END       = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  state_t state, state_nxt;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]  count;
  logic              flag_q, primed, evt;
  logic [31:0]       halt_cnt;
  logic              reason;
  logic [31:0]       dump_idx;
  logic [ADDR_W-1:0] dump_addr;
  logic              fifo_full, out_fire, char_mode, wd_hit;
  logic              push, pop, capture;

  assign evt        = primed && (print_flag != flag_q);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign out_fire   = out_valid && out_ready;
  assign char_mode  = (state == ST_RUN) || (state == ST_DRAIN);
  assign wd_hit     = (TIMEOUT != 0) && (cycle_count == TIMEOUT_M1);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
  assign dump_addr  = DUMP_BASE + ADDR_W'({dump_idx, 2'b00});
  // The presented character stays in the FIFO until accepted, so it counts against depth.
  assign pop        = char_mode && out_fire;

  assign mem_rd_en   = (state == ST_DUMP_REQ);
  assign mem_rd_addr = mem_rd_en ? dump_addr : '0;
  assign done        = (state == ST_DONE);
  assign dbg_state   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_RUN: begin
        push = evt && !fifo_full;
        if (halt || wd_hit) begin
          state_nxt = ST_DRAIN;
          capture   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if ((count == '0) || ((count == CNT_W'(1)) && out_fire))
          state_nxt = (DUMP_COUNT == 0) ? ST_END : ST_DUMP_REQ;
      end
      ST_DUMP_REQ:  state_nxt = ST_DUMP_WAIT;
      ST_DUMP_WAIT: state_nxt = ST_DUMP_OUT;
      ST_DUMP_OUT: begin
        if (out_fire) state_nxt = (dump_idx < DUMP_COUNT - 1) ? ST_DUMP_REQ : ST_END;
      end
      ST_END: begin
        if (out_fire) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q      <= 1'b0;
      primed      <= 1'b0;
      cycle_count <= '0;
      overflow    <= 1'b0;
      halt_cnt    <= '0;
      reason      <= 1'b0;
    end else begin
      flag_q <= print_flag;
      primed <= 1'b1;
      if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
      if ((state == ST_RUN) && evt && fifo_full) overflow <= 1'b1;
      if (capture) begin
        halt_cnt <= cycle_count;
        reason   <= !halt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= print_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_type  <= 2'd0;
      out_data  <= '0;
      out_addr  <= '0;
      dump_idx  <= '0;
    end else begin
      case (state)
        ST_RUN, ST_DRAIN: begin
          if (out_fire) begin
            if (count > CNT_W'(1)) begin
              out_data <= DATA_W'(fifo_mem[rd_ptr_nxt]);
            end else begin
              out_valid <= 1'b0;
            end
          end else if (!out_valid && (count != '0)) begin
            out_valid <= 1'b1;
            out_type  <= 2'd0;
            out_data  <= DATA_W'(fifo_mem[rd_ptr]);
            out_addr  <= '0;
          end
        end
        ST_DUMP_WAIT: begin
          out_valid <= 1'b1;
          out_type  <= 2'd1;
          out_data  <= mem_rd_data;
          out_addr  <= dump_addr;
        end
        ST_DUMP_OUT: begin
          if (out_fire) begin
            out_valid <= 1'b0;
            dump_idx  <= dump_idx + 32'd1;
          end
        end
        ST_END: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_type  <= 2'd2;
            out_data  <= DATA_W'(halt_cnt);
            out_addr  <= ADDR_W'(reason);
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_monitor.sv
// Bench for debug_monitor: console characters, FIFO overflow, halt/timeout dumps,
// random back-pressure and reset in the middle of a dump.
module tb_debug_monitor;

  localparam int DUMP_N = 10;
  localparam int TMO    = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        print_flag = 1'b0;
  logic [7:0]  print_data = 8'h00;
  logic        halt = 1'b0;
  logic        out_ready = 1'b0;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data = 32'h0;
  logic        out_valid;
  logic [1:0]  out_type;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        overflow;
  logic        done;
  logic [31:0] cycle_count;
  logic [2:0]  dbg_state;

  logic [31:0] mem [16];
  logic [67:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          got_words = 0;
  int          rd_pulses = 0;
  int          since_rst = 0;
  logic        prev_stall = 1'b0;
  logic        prev_rd_en = 1'b0;
  logic [67:0] prev_word = '0;

  debug_monitor #(
    .DATA_W(32), .ADDR_W(32), .FIFO_DEPTH(4), .DUMP_BASE(32'h0),
    .DUMP_COUNT(DUMP_N), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .print_flag(print_flag), .print_data(print_data), .halt(halt),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type), .out_data(out_data),
    .out_addr(out_addr), .overflow(overflow), .done(done), .cycle_count(cycle_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL sim_time_limit: got time %0t required finish earlier", $time);
    $fatal(1, "time limit");
  end

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[5:2]];
  end

  function automatic logic [67:0] pack(input logic [1:0] t, input logic [31:0] a,
                                       input logic [31:0] d);
    return {2'b00, t, a, d};
  endfunction

  task automatic check(input string tag, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_rd_en = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {out_valid, pack(out_type, out_addr, out_data)},
              {1'b1, prev_word});
      if (mem_rd_en) begin
        rd_pulses++;
        check("rd_single", 68'(prev_rd_en), 68'(0));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_extra", 68'(exp_q.size()), 68'(1));
        else check("sb_word", pack(out_type, out_addr, out_data), exp_q.pop_front());
        got_words++;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = pack(out_type, out_addr, out_data);
      prev_rd_en = mem_rd_en;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      since_rst++;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_en",   68'(mem_rd_en),   68'(0));
    check("rst_rd_addr", 68'(mem_rd_addr), 68'(0));
    check("rst_valid",   68'(out_valid),   68'(0));
    check("rst_type",    68'(out_type),    68'(0));
    check("rst_data",    68'(out_data),    68'(0));
    check("rst_addr",    68'(out_addr),    68'(0));
    check("rst_ovf",     68'(overflow),    68'(0));
    check("rst_done",    68'(done),        68'(0));
    check("rst_cycles",  68'(cycle_count), 68'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    halt = 1'b0;
    out_ready = 1'b0;
    tick(2);
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    since_rst = 0;
  endtask

  task automatic toggle_char(input logic [7:0] c);
    print_data = c;
    print_flag = ~print_flag;
  endtask

  task automatic expect_dump_end(input logic reason, input int cnt);
    for (int i = 0; i < DUMP_N; i++)
      exp_q.push_back(pack(2'd1, 32'(4 * i), 32'(DUMP_N - 1 - i)));
    exp_q.push_back(pack(2'd2, 32'(reason), 32'(cnt)));
  endtask

  // first tick is the edge that samples halt; n counts edges after it until done
  task automatic wait_done(input bit rnd, output int n);
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    tick(1);
    n = 0;
    while (!done && n < 500) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick(1);
      n++;
    end
    out_ready = 1'b1;
  endtask

  initial begin
    int n;
    int start;
    int base;
    int k;
    logic [7:0] chars [3];
    chars[0] = 8'h48;
    chars[1] = 8'h69;
    chars[2] = 8'h0A;
    for (int i = 0; i < 16; i++) mem[i] = (i < DUMP_N) ? 32'(DUMP_N - 1 - i) : 32'hDEAD_0000 + 32'(i);

    // console characters with latency checks
    do_reset();
    tick(2);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      toggle_char(chars[i]);
      exp_q.push_back(pack(2'd0, 32'h0, 32'(chars[i])));
      tick(1);
      check("char_lat_t0", 68'(out_valid), 68'(0));
      tick(1);
      check("char_lat_t1", 68'(out_valid), 68'(1));
      tick(2);
    end
    check("char_no_ovf", 68'(overflow), 68'(0));
    check("char_sb_empty", 68'(exp_q.size()), 68'(0));

    // overflow: depth 4, six back-to-back events while stalled
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      toggle_char(8'h61 + 8'(i));
      if (i < 4) exp_q.push_back(pack(2'd0, 32'h0, 32'h61 + 32'(i)));
      tick(1);
    end
    tick(2);
    check("ovf_set", 68'(overflow), 68'(1));
    check("ovf_head_valid", 68'(out_valid), 68'(1));
    out_ready = 1'b1;
    tick(8);
    check("ovf_sb_empty", 68'(exp_q.size()), 68'(0));
    check("ovf_sticky", 68'(overflow), 68'(1));

    // halt at cycle 200, full dump with ready held high
    do_reset();
    out_ready = 1'b1;
    while (since_rst < 200) tick(1);
    check("cycles_at_halt", 68'(cycle_count), 68'(200));
    halt = 1'b1;
    expect_dump_end(1'b0, 200);
    start = rd_pulses;
    wait_done(1'b0, n);
    check("done_latency", 68'(n), 68'(3 * DUMP_N + 3));
    check("dump_rd_pulses", 68'(rd_pulses - start), 68'(DUMP_N));
    check("dump_sb_empty", 68'(exp_q.size()), 68'(0));
    halt = 1'b0;
    toggle_char(8'h5A);
    tick(3);
    check("done_sticky", 68'(done), 68'(1));
    check("done_quiet", 68'(out_valid), 68'(0));

    // random back-pressure during the dump
    do_reset();
    out_ready = 1'b1;
    tick(30);
    halt = 1'b1;
    expect_dump_end(1'b0, 30);
    start = rd_pulses;
    wait_done(1'b1, n);
    check("rnd_done", 68'(done), 68'(1));
    check("rnd_rd_pulses", 68'(rd_pulses - start), 68'(DUMP_N));
    check("rnd_sb_empty", 68'(exp_q.size()), 68'(0));

    // watchdog timeout with halt never raised
    do_reset();
    out_ready = 1'b1;
    expect_dump_end(1'b1, TMO - 1);
    wait_done(1'b0, n);
    check("tmo_done", 68'(done), 68'(1));
    check("tmo_sb_empty", 68'(exp_q.size()), 68'(0));

    // reset in the middle of a dump, then a clean dump
    do_reset();
    out_ready = 1'b1;
    tick(20);
    halt = 1'b1;
    expect_dump_end(1'b0, 20);
    base = got_words;
    k = 0;
    while ((got_words - base) < 4 && k < 200) begin
      tick(1);
      k++;
    end
    check("mid_words_seen", 68'(got_words - base), 68'(4));
    rst = 1'b1;
    #1;
    check_reset_outputs();
    check("mid_state_run", 68'(dbg_state), 68'(0));
    exp_q.delete();
    do_reset();
    out_ready = 1'b1;
    tick(10);
    halt = 1'b1;
    expect_dump_end(1'b0, 10);
    start = rd_pulses;
    wait_done(1'b0, n);
    check("redump_latency", 68'(n), 68'(3 * DUMP_N + 3));
    check("redump_rd_pulses", 68'(rd_pulses - start), 68'(DUMP_N));
    check("redump_sb_empty", 68'(exp_q.size()), 68'(0));

    // report
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_monitor.md
# debug_monitor

Synthesizable run-time monitor for the pipelined RISC-V core. It captures console characters written by the program (print_flag toggle, character in x11), buffers them in a parametrised FIFO, and streams them out over a ready/valid port. On halt or watchdog timeout it drains the FIFO, dumps a configurable window of data memory through a read port, and emits an end marker. It sits beside Top, on the data-memory read side, and replaces bench-only print/dump code.

## Interface
- DATA_W, 32, memory word and stream data width
- ADDR_W, 32, byte address width
- FIFO_DEPTH, 16, character FIFO entries, power of 2, ≥2
- DUMP_BASE, 0, byte address of first dumped word (word aligned)
- DUMP_COUNT, 10, number of words dumped; 0 skips the dump
- TIMEOUT, 0, watchdog limit in cycles; 0 disables it
- clk  in  1  clock; rising edge
- rst  in  1  reset, asynchronous, active-high
- print_flag  in  1  console event; any change of level is one event
- print_data  in  8  character, low byte of x11, valid whenever print_flag changes
- halt  in  1  core halted, level
- mem_rd_en  out  1  data-memory read strobe
- mem_rd_addr  out  ADDR_W  read byte address
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
- out_valid  out  1  stream word valid
- out_ready  in  1  consumer accepts
- out_type  out  2  0 char, 1 dump word, 2 end marker
- out_data  out  DATA_W  char zero-extended / memory word / halt cycle count
- out_addr  out  ADDR_W  dump address; for end marker 0 = halt, 1 = timeout; 0 for chars
- overflow  out  1  sticky, a character was dropped
- done  out  1  sequence complete
- cycle_count  out  32  cycles since reset release, saturating

## Operation
- Event detect: flag_q holds the previous print_flag, and primed is cleared by reset. The first clock after reset loads flag_q and sets primed without generating an event. After that, print_flag != flag_q is one event.
- In RUN, an event pushes print_data. If the FIFO is full, the character is dropped and overflow is set until reset. An event in the same cycle as a pop is accepted whenever count < FIFO_DEPTH before the pop.
- Events arriving after RUN is exited are discarded without setting overflow.
- FSM states: RUN, DRAIN, DUMP_REQ, DUMP_WAIT, DUMP_OUT, END, DONE.
- RUN: streams FIFO characters. Moves to DRAIN when halt = 1 or the watchdog fires. An event in that same cycle is still pushed. cycle_count freezes into halt_cnt at that point.
- Watchdog: fires when TIMEOUT != 0 and cycle_count == TIMEOUT-1 with halt = 0. reason = 1 on timeout; halt takes priority in the same cycle (reason = 0).
- DRAIN: streams until the FIFO is empty and no word is pending. Then goes to DUMP_REQ, or to END if DUMP_COUNT = 0.
- DUMP_REQ: mem_rd_en = 1, mem_rd_addr = DUMP_BASE + 4·i, with i starting at 0. Next state is DUMP_WAIT.
- DUMP_WAIT: registers mem_rd_data and goes to DUMP_OUT.
- DUMP_OUT: out_valid = 1, out_type = 1, out_addr = DUMP_BASE + 4·i. On out_ready, i increments; the FSM goes to DUMP_REQ if i < DUMP_COUNT-1, else END.
- END: out_type = 2, out_data = halt_cnt, out_addr = reason. On out_ready, goes to DONE.
- DONE: done = 1, out_valid = 0. Stays here until reset; halt and events are ignored.
- Stream rule: once out_valid = 1, out_type, out_data and out_addr hold until out_ready. out_valid never depends combinationally on out_ready.
- cycle_count increments every cycle after reset release and saturates at 0xFFFFFFFF.
- Reset mid-operation returns everything to RUN at once: FIFO empties, counters clear, any dump in progress is abandoned.

## Timing
- Reset values: mem_rd_en = 0, mem_rd_addr = 0, out_valid = 0, out_type = 0, out_data = 0, out_addr = 0, overflow = 0, done = 0, cycle_count = 0.
- Character latency: an event sampled at edge t writes the FIFO at t. out_valid rises after edge t+1 (output register). Sustained throughput is 1 character per cycle with out_ready = 1.
- Dump: 3 cycles per word with out_ready held high (REQ, WAIT, OUT). mem_rd_en pulses for exactly 1 cycle per word.
- halt sampled at t with an empty FIFO: DUMP_REQ in the cycle after t+1 (one DRAIN cycle).
- Full sequence for DUMP_COUNT = N with out_ready = 1: done rises 3N+3 cycles after halt is sampled.

## Test plan
- Toggle print_flag 3 times with 'H', 'i', '\n', out_ready = 1 → three type-0 words 0x48, 0x69, 0x0A in order, each 2 cycles after its toggle; overflow = 0.
- FIFO_DEPTH = 4, out_ready = 0, 6 events → 4 retained; overflow = 1. Raising out_ready yields the first 4 characters only.
- Memory preloaded mem[0..9] = 9..0 with DUMP_BASE = 0, DUMP_COUNT = 10, halt at cycle 200 → 10 type-1 words with addr 0, 4, …, 36 and data 9..0. Then a type-2 word with out_data = 200, out_addr = 0, then done = 1.
- Random out_ready (50%) during the dump → outputs stable while stalled, no duplicate or missing words, exactly 10 mem_rd_en pulses.
- TIMEOUT = 50, halt never asserted → a type-2 word with out_data = 49, out_addr = 1. Dump precedes it.
- Assert rst mid-dump (after word 3) → all outputs return to reset values at once. After release, a new halt produces a full 10-word dump starting at address 0.
